// File: rtl/cpu_pkg.sv
// Shared CPU types: address/instruction widths, reset PC and the fetch queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int                ADDR_W   = 32;
   localparam int                INSTR_W  = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = '0;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch_entry_t; head entry is visible combinationally.
// Latency: an entry pushed at edge N is at the head in cycle N+1.
// Backpressure: caller must not push while o_full; flush overrides push and pop.
// Ports: i_push/i_push_dat write, i_pop advance head, i_flush empty the queue,
//        o_head_dat head entry, o_full/o_empty/o_count occupancy.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  fetch_entry_t           i_push_dat,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output fetch_entry_t           o_head_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;

   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_count    = r_count;
   assign o_head_dat = r_mem[r_rd_ptr];
   assign w_pop      = i_pop & ~o_empty;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem request/response tracking, prefetch queue, redirect.
// Latency: response captured at edge N -> instr_valid in cycle N+1; 1 instr/cycle sustained.
// Backpressure: requests stop when queue occupancy + in-flight would exceed DEPTH.
// Ports: imem_req_* / imem_addr request side, imem_rsp_* response side,
//        PCSrc/BranchTarget redirect, instr_* / Instr / PCPlus8 to decode.
module fetch_unit
   import cpu_pkg::fetch_entry_t;
#(
   parameter int                ADDR_W   = cpu_pkg::ADDR_W,
   parameter int                INSTR_W  = cpu_pkg::INSTR_W,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               PCSrc,
   input  logic [ADDR_W-1:0]  BranchTarget,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] Instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  PCPlus8
);

   localparam int CW = $clog2(DEPTH) + 1;   // counts 0..DEPTH
   localparam int SW = CW + 1;              // occupancy + outstanding

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_rsp_pc;             // pc of the next non-stale response
   logic [CW-1:0]     r_outstanding;
   logic [CW-1:0]     r_discard;

   logic              w_fire;
   logic              w_drop;
   logic              w_push;
   logic              w_pop;
   logic              w_space;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [SW-1:0]     w_used;
   logic [CW-1:0]     w_outstanding_nxt;
   logic [ADDR_W-1:0] w_target;
   fetch_entry_t      w_push_dat;
   fetch_entry_t      w_head;

   assign w_target   = {BranchTarget[ADDR_W-1:2], 2'b00};
   assign w_fire     = imem_req_valid & imem_req_ready;
   assign w_drop     = imem_rsp_valid & (r_discard != '0);
   assign w_push     = imem_rsp_valid & ~w_drop & ~w_full;
   assign w_pop      = instr_valid & instr_ready;
   assign w_push_dat = '{instr: imem_rsp_data, pc: r_rsp_pc};

   // A pop this cycle frees a slot by the time a new request can return,
   // which is what lets DEPTH = latency + 1 sustain one instruction per cycle.
   assign w_used  = {1'b0, w_count} + {1'b0, r_outstanding};
   assign w_space = (w_used < SW'(DEPTH)) | (w_pop & (w_used == SW'(DEPTH)));

   assign w_outstanding_nxt = r_outstanding + CW'(w_fire) - CW'(imem_rsp_valid);

   assign imem_req_valid = ~reset & (r_discard == '0) & w_space;
   assign imem_addr      = reset ? RESET_PC : r_fetch_pc;
   assign instr_valid    = ~reset & ~w_empty;
   assign Instr          = instr_valid ? w_head.instr : '0;
   assign instr_pc       = instr_valid ? w_head.pc : RESET_PC;
   assign PCPlus8        = instr_pc + ADDR_W'(8);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         if (PCSrc) begin
            // Everything still in flight after this edge (including a request
            // accepted right now) belongs to the old stream and must be dropped.
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
            r_discard  <= w_outstanding_nxt;
         end else begin
            if (w_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            if (w_push) r_rsp_pc   <= r_rsp_pc + ADDR_W'(4);
            if (w_drop) r_discard  <= r_discard - CW'(1);
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .i_flush    (PCSrc),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

endmodule
